// File: rtl/txwbcnt_sfifo.sv
// Single-clock TX write-byte-count FIFO. It has show-ahead or registered read,
// almost-full/almost-empty thresholds, a synchronous flush, and sticky
// overflow/underflow flags.
module txwbcnt_sfifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned PTR       = 8,
    parameter int unsigned SHOWAHEAD = 1,
    parameter int unsigned AFULL_TH  = 240,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [PTR:0]     usedw,
    output logic             ovf,
    output logic             udf
);

    localparam int unsigned CW = PTR + 1;

    logic [PTR-1:0]   wrptr_q, wrptr_d;
    logic [PTR-1:0]   rdptr_q, rdptr_d;
    logic [CW-1:0]    usedw_q, usedw_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_ok, wr_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Status flags decoded from the registered occupancy
    always_comb begin
        full   = (usedw_q == CW'(DEPTH));
        empty  = (usedw_q == '0);
        afull  = (usedw_q >= CW'(AFULL_TH));
        aempty = (usedw_q <= CW'(AEMPTY_TH));
        usedw  = usedw_q;
        ovf    = ovf_q;
        udf    = udf_q;
    end

    // Accept logic, pointer and occupancy next state, and error flags
    always_comb begin
        rd_ok   = rden & ~empty;
        wr_ok   = wren & (~full | rd_ok);
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        usedw_d = usedw_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wrptr_d = '0;
            rdptr_d = '0;
            usedw_d = '0;
        end else begin
            if (wr_ok) wrptr_d = wrptr_q + PTR'(1);
            if (rd_ok) rdptr_d = rdptr_q + PTR'(1);
            case ({wr_ok, rd_ok})
                2'b10:   usedw_d = usedw_q + CW'(1);
                2'b01:   usedw_d = usedw_q - CW'(1);
                default: usedw_d = usedw_q;
            endcase
            if (wren & full & ~rd_ok) ovf_d = 1'b1;
            if (rden & empty)         udf_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            usedw_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            usedw_q <= usedw_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are not cleared by reset or flush
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_ok) mem_q[wrptr_q] <= datain;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign dataout = mem_q[rdptr_q];
        end else begin : g_regread
            logic [WIDTH-1:0] dout_q;
            // Registered read port, loaded only on an accepted pop
            always_ff @(posedge clk) begin
                if (reset)                dout_q <= '0;
                else if (!flush && rd_ok) dout_q <= mem_q[rdptr_q];
            end
            assign dataout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_txwbcnt_sfifo.sv
// Bench for txwbcnt_sfifo. Instance A is the default show-ahead 256x64 build.
// Instance B is a 16x16 build with a registered read port. Both are checked
// every cycle against queue models, and directed steps add literal checks.
module tb_txwbcnt_sfifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instance A (show-ahead, 256 deep) ----------------
    logic        rst_a = 1'b1, flush_a = 1'b0, wren_a = 1'b0, rden_a = 1'b0;
    logic [63:0] din_a = '0, dout_a;
    logic        full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
    logic [8:0]  usedw_a;

    txwbcnt_sfifo u_a (
        .clk(clk), .reset(rst_a), .flush(flush_a), .wren(wren_a), .datain(din_a),
        .rden(rden_a), .dataout(dout_a), .full(full_a), .empty(empty_a),
        .afull(afull_a), .aempty(aempty_a), .usedw(usedw_a), .ovf(ovf_a), .udf(udf_a)
    );

    // ---------------- instance B (registered read, 16 deep) ----------------
    logic        rst_b = 1'b1, flush_b = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
    logic [15:0] din_b = '0, dout_b;
    logic        full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;
    logic [4:0]  usedw_b;

    txwbcnt_sfifo #(
        .WIDTH(16), .DEPTH(16), .PTR(4), .SHOWAHEAD(0), .AFULL_TH(12), .AEMPTY_TH(2)
    ) u_b (
        .clk(clk), .reset(rst_b), .flush(flush_b), .wren(wren_b), .datain(din_b),
        .rden(rden_b), .dataout(dout_b), .full(full_b), .empty(empty_b),
        .afull(afull_b), .aempty(aempty_b), .usedw(usedw_b), .ovf(ovf_b), .udf(udf_b)
    );

    // ---------------- reference models ----------------
    logic [63:0] qa[$];
    logic [15:0] qb[$];
    logic        movf_a = 0, mudf_a = 0, movf_b = 0, mudf_b = 0;
    logic [15:0] mdout_b = '0;
    bit          live = 0;

    // The queue models are the FIFO contents; pops happen before pushes in each cycle.
    always @(posedge clk) begin
        bit rd, wr;
        if (rst_a) begin
            qa.delete(); movf_a = 0; mudf_a = 0;
        end else if (flush_a) begin
            qa.delete();
        end else begin
            rd = rden_a && qa.size() != 0;
            wr = wren_a && (qa.size() < 256 || rd);
            if (wren_a && qa.size() == 256 && !rd) movf_a = 1;
            if (rden_a && qa.size() == 0) mudf_a = 1;
            if (rd) void'(qa.pop_front());
            if (wr) qa.push_back(din_a);
        end
        if (rst_b) begin
            qb.delete(); movf_b = 0; mudf_b = 0; mdout_b = '0;
        end else if (flush_b) begin
            qb.delete();
        end else begin
            rd = rden_b && qb.size() != 0;
            wr = wren_b && (qb.size() < 16 || rd);
            if (wren_b && qb.size() == 16 && !rd) movf_b = 1;
            if (rden_b && qb.size() == 0) mudf_b = 1;
            if (rd) mdout_b = qb.pop_front();
            if (wr) qb.push_back(din_b);
        end
    end

    // Compare both instances against the models on every falling edge
    always @(negedge clk) begin
        if (live) begin
            chk("a_usedw",  64'(usedw_a),  64'(qa.size()));
            chk("a_full",   64'(full_a),   64'(qa.size() == 256));
            chk("a_empty",  64'(empty_a),  64'(qa.size() == 0));
            chk("a_afull",  64'(afull_a),  64'(qa.size() >= 240));
            chk("a_aempty", 64'(aempty_a), 64'(qa.size() <= 4));
            chk("a_ovf",    64'(ovf_a),    64'(movf_a));
            chk("a_udf",    64'(udf_a),    64'(mudf_a));
            if (qa.size() != 0) chk("a_dataout", dout_a, qa[0]);
            chk("b_usedw",  64'(usedw_b),  64'(qb.size()));
            chk("b_full",   64'(full_b),   64'(qb.size() == 16));
            chk("b_empty",  64'(empty_b),  64'(qb.size() == 0));
            chk("b_afull",  64'(afull_b),  64'(qb.size() >= 12));
            chk("b_aempty", 64'(aempty_b), 64'(qb.size() <= 2));
            chk("b_ovf",    64'(ovf_b),    64'(movf_b));
            chk("b_udf",    64'(udf_b),    64'(mudf_b));
            chk("b_dataout", 64'(dout_b),  64'(mdout_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        wren_a = 0; rden_a = 0; flush_a = 0;
    endtask

    initial begin
        int wrote, cyc;
        step(); step();
        rst_a = 0; rst_b = 0;
        live = 1;
        chk("a_reset_empty", 64'(empty_a), 64'd1);
        chk("a_reset_usedw", 64'(usedw_a), 64'd0);
        chk("b_reset_dout",  64'(dout_b),  64'd0);

        // 1: write 1..5, then read them back in order
        for (int i = 1; i <= 5; i++) begin
            wren_a = 1; din_a = 64'(i);
            step();
            if (i == 1) begin
                chk("t1_empty_after_first", 64'(empty_a), 64'd0);
                chk("t1_head", dout_a, 64'h1);
            end
            if (i == 4) chk("t1_aempty_at4", 64'(aempty_a), 64'd1);
        end
        idle_a();
        chk("t1_usedw", 64'(usedw_a), 64'd5);
        chk("t1_aempty_at5", 64'(aempty_a), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            chk("t1_readorder", dout_a, 64'(i));
            rden_a = 1; step();
        end
        idle_a();
        chk("t1_drained", 64'(empty_a), 64'd1);

        // 3: read while empty, then read+write while empty
        rden_a = 1; step();
        chk("t3_udf", 64'(udf_a), 64'd1);
        chk("t3_usedw", 64'(usedw_a), 64'd0);
        wren_a = 1; din_a = 64'h77; step();
        idle_a();
        chk("t3_usedw_rw", 64'(usedw_a), 64'd1);
        chk("t3_head", dout_a, 64'h77);
        rden_a = 1; step(); idle_a();

        // 2: fill to full, overflow, then write+read while full
        for (int i = 0; i < 256; i++) begin
            wren_a = 1; din_a = 64'h1000 + 64'(i); step();
            if (i == 238) chk("t2_afull_239", 64'(afull_a), 64'd0);
            if (i == 239) chk("t2_afull_240", 64'(afull_a), 64'd1);
        end
        chk("t2_full", 64'(full_a), 64'd1);
        chk("t2_usedw", 64'(usedw_a), 64'd256);
        din_a = 64'hDEAD; step();
        chk("t2_ovf", 64'(ovf_a), 64'd1);
        chk("t2_usedw_ovf", 64'(usedw_a), 64'd256);
        rden_a = 1; din_a = 64'hBEEF; step();
        idle_a();
        chk("t2_usedw_rw", 64'(usedw_a), 64'd256);
        chk("t2_head_adv", dout_a, 64'h1001);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("t2_last_word", dout_a, 64'hBEEF);
            rden_a = 1; step();
        end
        idle_a();

        // 4: random 50% wren/rden until 600 words accepted
        wrote = 0; cyc = 0;
        while (wrote < 600 && cyc < 5000) begin
            wren_a = 1'($urandom_range(0, 1));
            rden_a = 1'($urandom_range(0, 1));
            din_a  = {$urandom, $urandom};
            if (wren_a && (qa.size() < 256 || (rden_a && qa.size() != 0))) wrote++;
            step(); cyc++;
        end
        chk("t4_budget", 64'(wrote >= 600), 64'd1);
        idle_a();
        cyc = 0;
        while (qa.size() != 0 && cyc < 1000) begin
            rden_a = 1; step(); cyc++;
        end
        idle_a();
        chk("t4_drain", 64'(empty_a), 64'd1);

        // 5: flush with concurrent wren/rden at usedw=100
        for (int i = 0; i < 100; i++) begin
            wren_a = 1; din_a = 64'(i); step();
        end
        chk("t5_usedw100", 64'(usedw_a), 64'd100);
        flush_a = 1; wren_a = 1; rden_a = 1; din_a = 64'h55; step();
        idle_a();
        chk("t5_usedw", 64'(usedw_a), 64'd0);
        chk("t5_empty", 64'(empty_a), 64'd1);
        chk("t5_aempty", 64'(aempty_a), 64'd1);
        chk("t5_ovf_kept", 64'(ovf_a), 64'd1);
        chk("t5_udf_kept", 64'(udf_a), 64'd1);
        wren_a = 1; din_a = 64'hAA; step(); idle_a();
        chk("t5_readback", dout_a, 64'hAA);
        rden_a = 1; step(); idle_a();

        // 6: registered-read instance
        wren_b = 1; din_b = 16'h1234; step(); wren_b = 0;
        rden_b = 1; step(); rden_b = 0;
        chk("t6_dout", 64'(dout_b), 64'h1234);
        step(); step();
        chk("t6_dout_hold", 64'(dout_b), 64'h1234);
        for (int i = 0; i < 17; i++) begin
            wren_b = 1; din_b = 16'h0A00 + 16'(i); step();
        end
        wren_b = 0;
        chk("t6_full", 64'(full_b), 64'd1);
        chk("t6_ovf", 64'(ovf_b), 64'd1);
        for (int i = 0; i < 7; i++) begin
            rden_b = 1; step();
        end
        rden_b = 0;
        chk("t6_usedw9", 64'(usedw_b), 64'd9);
        chk("t6_dout_last", 64'(dout_b), 64'h0A06);
        rst_b = 1; wren_b = 1; rden_b = 1; din_b = 16'hFFFF; step();
        rst_b = 0; wren_b = 0; rden_b = 0;
        chk("t6_rst_usedw", 64'(usedw_b), 64'd0);
        chk("t6_rst_empty", 64'(empty_b), 64'd1);
        chk("t6_rst_aempty", 64'(aempty_b), 64'd1);
        chk("t6_rst_full", 64'(full_b), 64'd0);
        chk("t6_rst_ovf", 64'(ovf_b), 64'd0);
        chk("t6_rst_dout", 64'(dout_b), 64'd0);
        step(); step();

        live = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/txwbcnt_sfifo.md
Name: txwbcnt_sfifo

Overview:
Parametrised single-clock successor to the TX write-byte-count FIFO. It buffers per-frame byte-count words between the AXIS bridge TX write path and the MAC TX scheduler in the same clock domain. Over the fixed 256x64 dual-clock version it adds:
- selectable show-ahead (first-word-fall-through) or registered-read mode
- almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow and underflow error flags

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 256, number of entries; must equal 2**PTR
PTR, 8, pointer width; occupancy counters are PTR+1 bits
SHOWAHEAD, 1, 1 = head word visible on dataout while !empty; 0 = dataout registered, valid the cycle after an accepted read
AFULL_TH, 240, afull asserts when usedw >= AFULL_TH
AEMPTY_TH, 4, aempty asserts when usedw <= AEMPTY_TH

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous active-high reset
flush  in  1  synchronous clear of contents; highest priority
wren  in  1  write request
datain  in  WIDTH  write data
rden  in  1  read request / pop
dataout  out  WIDTH  read data
full  out  1  usedw == DEPTH
empty  out  1  usedw == 0
afull  out  1  usedw >= AFULL_TH
aempty  out  1  usedw <= AEMPTY_TH
usedw  out  PTR+1  current occupancy, 0..DEPTH
ovf  out  1  sticky: write attempted while full and not accepted
udf  out  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset (sampled on the clk edge):
  - wrptr = rdptr = 0, usedw = 0
  - empty = 1, full = 0, afull = 0, aempty = 1
  - ovf = 0, udf = 0
  - dataout = 0 in SHOWAHEAD=0 mode
  - Memory contents are not reset.
- Priority: reset > flush > normal operation.
- Flush:
  - Pointers and usedw go to 0 on the next edge; wren and rden in the same cycle are ignored.
  - ovf and udf are unchanged by flush.
  - SHOWAHEAD=0: dataout holds its value.
- Accepted read: rd_ok = rden & !empty.
- Accepted write: wr_ok = wren & (!full | rd_ok), so a write to a full FIFO succeeds when a read is accepted in the same cycle.
- Pointer and occupancy update on the next edge:
  - wr_ok writes mem[wrptr] and increments wrptr.
  - rd_ok increments rdptr.
  - Pointers are PTR bits and wrap DEPTH-1 -> 0 silently.
  - usedw: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Status outputs: full, empty, afull and aempty are combinational decodes of the registered usedw, so all flags move on the same edge as usedw.
- Errors:
  - ovf sets on the next edge when wren & full & !rd_ok.
  - udf sets on the next edge when rden & empty.
  - Both hold until reset.
  - The offending operation has no effect on pointers, usedw or memory.
- SHOWAHEAD=1:
  - dataout = mem[rdptr] combinationally.
  - The first word written into an empty FIFO appears on dataout, with empty=0, one cycle after the write edge.
  - On rd_ok the next word appears after the edge.
  - dataout is don't-care while empty.
- SHOWAHEAD=0:
  - dataout <= mem[rdptr] on rd_ok; latency is 1 cycle from rden to data.
  - Otherwise dataout holds.
- No data corruption across pointer wrap; words are read out in write order.
- Simultaneous read and write on an empty FIFO: the read is rejected (udf sets), the write is accepted, and usedw becomes 1.

Test Plan:
1. Reset, then write 0x1..0x5 on consecutive cycles; SHOWAHEAD=1 -> empty deasserts the cycle after the first write, dataout=0x1, usedw=5, aempty=0 after the 5th write (AEMPTY_TH=4), and reads return 0x1..0x5 in order.
2. Fill 256 words -> full=1 and usedw=256; afull first asserts when usedw reaches 240. A further wren -> ovf=1 and usedw stays 256. Simultaneous wren+rden while full -> usedw stays 256, head word advances, and the new word is stored.
3. rden while empty after reset -> udf=1, usedw=0, and wrptr/rdptr remain unchanged. A concurrent wren -> usedw=1.
4. Stream 600 words with random wren/rden at a 50% duty cycle -> the scoreboard matches every word across the 2 pointer wraps, and usedw always equals writes minus reads.
5. With usedw=100, assert flush together with wren and rden -> next cycle usedw=0, empty=1, aempty=1, and ovf/udf are unchanged. A subsequent write of 0xAA reads back as 0xAA.
6. SHOWAHEAD=0, WIDTH=16, DEPTH=16, PTR=4: write 0x1234, then rden -> dataout=0x1234 one cycle after rden and held while rden=0. Assert reset mid-stream with usedw=9 -> all outputs return to reset values on the next edge.
